// File: rtl/counter_reg_pkg.sv
// Shared types and constants for the up/down counter register.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package counter_reg_pkg;

    // Count direction as carried on the dir input.
    typedef enum logic {
        CNT_UP   = 1'b0,
        CNT_DOWN = 1'b1
    } cnt_dir_e;

    // Conventional single-step increment (PC / loop counter use).
    localparam int unsigned STEP_ONE = 1;

endpackage : counter_reg_pkg

// File: rtl/counter_step_adder.sv
// Next-value datapath: value +/- zero-extended step with carry/borrow out.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   i_value  current counter value       i_step  unsigned step
//   i_dir    CNT_UP / CNT_DOWN           o_next  next value   o_carry  carry (up) / borrow (down)
// Build option: UPDOWN_COUNTER_REG_SAT_EN clamps instead of wrapping on carry/borrow.
module counter_step_adder
    import counter_reg_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STEP_W = 4
) (
    input  logic [WIDTH-1:0]  i_value,
    input  logic [STEP_W-1:0] i_step,
    input  cnt_dir_e          i_dir,
    output logic [WIDTH-1:0]  o_next,
    output logic              o_carry
);

    logic [WIDTH:0] w_value_ext;
    logic [WIDTH:0] w_step_ext;
    logic [WIDTH:0] w_sum;

    assign w_value_ext = {1'b0, i_value};
    assign w_step_ext  = {{(WIDTH + 1 - STEP_W){1'b0}}, i_step};

    // One extra bit: on the way down it becomes the borrow because the
    // subtraction underflows into bit WIDTH exactly when value < step.
    assign w_sum   = (i_dir == CNT_UP) ? (w_value_ext + w_step_ext)
                                       : (w_value_ext - w_step_ext);
    assign o_carry = w_sum[WIDTH];

`ifdef UPDOWN_COUNTER_REG_SAT_EN
    // Clamp to the rail in the direction of travel.
    always_comb begin
        o_next = w_sum[WIDTH-1:0];
        if (w_sum[WIDTH]) begin
            o_next = (i_dir == CNT_UP) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        end
    end
`else
    assign o_next = w_sum[WIDTH-1:0];
`endif

endmodule : counter_step_adder

// File: rtl/updown_counter_reg.sv
// Loadable up/down counter register with carry/sticky-overflow flags and two tri-state read ports.
// Latency: value/carry/ovf one edge after ld/cnt; a, b and zero combinational from the register.
// Backpressure: none; ld and cnt are accepted on every rising edge (ld wins over cnt).
//
// Ports:
//   clk, rst_n (async, active-low)   in/ld load data/strobe   cnt/dir/step count request
//   oe_a/oe_b  bus enables            a/b tri-state read ports  carry/ovf/zero status flags
// Build option: UPDOWN_COUNTER_REG_SAT_EN makes counting saturate instead of wrapping.
module updown_counter_reg
    import counter_reg_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               STEP_W    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in,
    input  logic              ld,
    input  logic              cnt,
    input  logic              dir,
    input  logic [STEP_W-1:0] step,
    input  logic              oe_a,
    input  logic              oe_b,
    output logic [WIDTH-1:0]  a,
    output logic [WIDTH-1:0]  b,
    output logic              carry,
    output logic              ovf,
    output logic              zero
);

    logic [WIDTH-1:0] r_value;
    logic             r_carry;
    logic             r_ovf;

    cnt_dir_e         w_dir;
    logic [WIDTH-1:0] w_next;
    logic             w_carry;

    assign w_dir = cnt_dir_e'(dir);

    counter_step_adder #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_step_adder (
        .i_value (r_value),
        .i_step  (step),
        .i_dir   (w_dir),
        .o_next  (w_next),
        .o_carry (w_carry)
    );

    // carry is a one-cycle pulse: every edge that is not a carrying count
    // (hold, load, or a non-carrying count) drops it back to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= RESET_VAL;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (ld) begin
            r_value <= in;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (cnt) begin
            r_value <= w_next;
            r_carry <= w_carry;
            r_ovf   <= r_ovf | w_carry;
        end else begin
            r_carry <= 1'b0;
        end
    end

    // Bus drivers float when not enabled so other registers can share the bus.
    assign a     = oe_a ? r_value : {WIDTH{1'bz}};
    assign b     = oe_b ? r_value : {WIDTH{1'bz}};
    assign carry = r_carry;
    assign ovf   = r_ovf;
    assign zero  = (r_value == '0);

endmodule : updown_counter_reg
